hazard_controller: RTL and testbench



---
 rtl/hazard_controller_pkg.sv | 35 +++
 rtl/hazard_controller_if.sv | 30 +++
 rtl/hazard_controller_md_latency_counter.sv | 27 ++
 rtl/hazard_controller.sv | 126 ++++++++++++
 tb/tb_hazard_controller.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/hazard_controller_pkg.sv
// Shared types for the decode-side hazard controller: decoded instruction view, bypass selects, FSM states.
package hazard_controller_pkg;

    localparam int MUL_LATENCY_DEF = 3;
    localparam int DIV_LATENCY_DEF = 8;
    localparam int PERF_WIDTH_DEF  = 32;

    typedef struct packed {
        logic       valid;
        logic [4:0] src_reg_1;
        logic [4:0] src_reg_2;
        logic [4:0] dst_reg;
        logic       reg_write_enable;
        logic       is_l;
        logic       is_m;
        logic [2:0] func3;
    } inst_decoded_t;

    typedef struct packed {
        logic dep_src1;
        logic dep_src2;
    } bypass_t;

    typedef enum logic [1:0] {
        RUN,
        LD_STALL,
        MD_WAIT
    } hz_state_t;

    // x0 is hardwired, so a producer writing it never creates a dependency.
    function automatic logic dep_match(inst_decoded_t prod, logic [4:0] src);
        return prod.valid & prod.reg_write_enable & (prod.dst_reg != 5'd0) & (prod.dst_reg == src);
    endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Bundle between the pipeline (master) and the hazard controller (slave).
interface hazard_controller_if
    import hazard_controller_pkg::*;
#(
    parameter int PERF_WIDTH = 32
);
    inst_decoded_t          inst_dec_in;
    inst_decoded_t          inst_exe_in;
    inst_decoded_t          inst_mem_in;
    logic                   branch_taken_in;
    bypass_t                exe_bypass;
    bypass_t                mem_bypass;
    logic                   load_to_use_hazard;
    logic                   stall_fetch;
    logic                   flush_dec;
    logic                   md_busy;
    logic [PERF_WIDTH-1:0]  stall_cycles;

    modport master (
        output inst_dec_in, inst_exe_in, inst_mem_in, branch_taken_in,
        input  exe_bypass, mem_bypass, load_to_use_hazard, stall_fetch,
               flush_dec, md_busy, stall_cycles
    );

    modport slave (
        input  inst_dec_in, inst_exe_in, inst_mem_in, branch_taken_in,
        output exe_bypass, mem_bypass, load_to_use_hazard, stall_fetch,
               flush_dec, md_busy, stall_cycles
    );
endinterface

// File: rtl/hazard_controller_md_latency_counter.sv
// Loadable down-counter timing multi-cycle MUL/DIV occupancy of EXE.
// Latency: load visible next cycle; no backpressure, decrements every cycle while non-zero.
module hazard_controller_md_latency_counter #(
    parameter int CW = 4
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_value,
    output logic          o_busy,
    output logic          o_done
);
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_busy = (r_cnt != '0);
    assign o_done = (r_cnt == CW'(1));
endmodule

// File: rtl/hazard_controller.sv
// Decode-side hazard controller: bypass selects, load-use/MUL-DIV stalls, branch flush, stall counter.
// Latency: all control outputs combinational from current inputs/state; no backpressure of its own.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int MUL_LATENCY = MUL_LATENCY_DEF,
    parameter int DIV_LATENCY = DIV_LATENCY_DEF,
    parameter int PERF_WIDTH  = PERF_WIDTH_DEF
)(
    input  logic                clk,
    input  logic                rst,
    hazard_controller_if.slave  io_hz
);
    localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
    localparam int CW      = $clog2(MAX_LAT + 1);

    hz_state_t             r_state;
    hz_state_t             w_next;
    logic [PERF_WIDTH-1:0] r_stall_cycles;
    logic [CW-1:0]         w_load_value;
    bypass_t               w_exe_bp;
    bypass_t               w_mem_bp;
    logic                  w_ld_hz;
    logic                  w_branch;
    logic                  w_md_issue;
    logic                  w_ld_out;
    logic                  w_stall;
    logic                  w_stall_out;
    logic                  w_cnt_busy;
    logic                  w_cnt_done;
    logic                  w_unused;

    assign w_exe_bp.dep_src1 = dep_match(io_hz.inst_exe_in, io_hz.inst_dec_in.src_reg_1);
    assign w_exe_bp.dep_src2 = dep_match(io_hz.inst_exe_in, io_hz.inst_dec_in.src_reg_2);
    assign w_mem_bp.dep_src1 = dep_match(io_hz.inst_mem_in, io_hz.inst_dec_in.src_reg_1);
    assign w_mem_bp.dep_src2 = dep_match(io_hz.inst_mem_in, io_hz.inst_dec_in.src_reg_2);

    assign w_ld_hz = io_hz.inst_dec_in.valid & io_hz.inst_exe_in.is_l
                   & (w_exe_bp.dep_src1 | w_exe_bp.dep_src2);

    // A branch cannot resolve while a MUL/DIV holds EXE; treat one seen there as noise.
    assign w_branch = io_hz.branch_taken_in & (r_state != MD_WAIT);

    assign w_load_value = io_hz.inst_dec_in.func3[2] ? CW'(DIV_LATENCY - 1)
                                                     : CW'(MUL_LATENCY - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_ld_out   = 1'b0;
        w_stall    = 1'b0;
        w_md_issue = 1'b0;
        case (r_state)
            RUN: begin
                if (w_branch) begin
                    w_next = RUN;
                end else if (w_ld_hz) begin
                    w_ld_out = 1'b1;
                    w_stall  = 1'b1;
                    w_next   = LD_STALL;
                end else if (io_hz.inst_dec_in.valid & io_hz.inst_dec_in.is_m) begin
                    w_md_issue = 1'b1;
                    if (w_load_value != '0) begin
                        w_next = MD_WAIT;
                    end
                end
            end
            LD_STALL: begin
                w_next = RUN;
            end
            MD_WAIT: begin
                w_ld_out = 1'b1;
                w_stall  = 1'b1;
                if (w_cnt_done) begin
                    w_next = RUN;
                end
            end
            default: begin
                w_next = RUN;
            end
        endcase
    end

    hazard_controller_md_latency_counter #(
        .CW (CW)
    ) u_md_cnt (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_md_issue),
        .i_load_value (w_load_value),
        .o_busy       (w_cnt_busy),
        .o_done       (w_cnt_done)
    );

    assign w_stall_out = w_stall & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (w_stall_out && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign io_hz.exe_bypass         = w_exe_bp;
    assign io_hz.mem_bypass         = w_mem_bp;
    assign io_hz.load_to_use_hazard = w_ld_out & ~rst;
    assign io_hz.stall_fetch        = w_stall_out;
    assign io_hz.flush_dec          = w_branch & ~rst;
    assign io_hz.md_busy            = w_cnt_busy & ~rst;
    assign io_hz.stall_cycles       = r_stall_cycles;

    assign w_unused = ^{io_hz.inst_dec_in.dst_reg, io_hz.inst_dec_in.reg_write_enable,
                        io_hz.inst_dec_in.is_l, io_hz.inst_dec_in.func3[1:0],
                        io_hz.inst_exe_in.src_reg_1, io_hz.inst_exe_in.src_reg_2,
                        io_hz.inst_exe_in.is_m, io_hz.inst_exe_in.func3,
                        io_hz.inst_mem_in.src_reg_1, io_hz.inst_mem_in.src_reg_2,
                        io_hz.inst_mem_in.is_l, io_hz.inst_mem_in.is_m, io_hz.inst_mem_in.func3};
endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller with an expected-output queue; a second instance covers counter saturation.
module tb_hazard_controller;
    import hazard_controller_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_controller_if #(.PERF_WIDTH(32)) hz();
    hazard_controller_if #(.PERF_WIDTH(4))  hz4();

    hazard_controller #(.MUL_LATENCY(3), .DIV_LATENCY(8), .PERF_WIDTH(32)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .io_hz (hz)
    );

    hazard_controller #(.MUL_LATENCY(3), .DIV_LATENCY(21), .PERF_WIDTH(4)) u_sat (
        .clk   (clk),
        .rst   (rst),
        .io_hz (hz4)
    );

    typedef struct {
        string       tag;
        logic [1:0]  eb;
        logic [1:0]  mb;
        logic        ld;
        logic        st;
        logic        fl;
        logic        bz;
        logic [31:0] sc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_sc   = 32'd0;

    function automatic inst_decoded_t mk(logic v, logic [4:0] s1, logic [4:0] s2, logic [4:0] d,
                                         logic we, logic l, logic m, logic [2:0] f3);
        inst_decoded_t t;
        t.valid            = v;
        t.src_reg_1        = s1;
        t.src_reg_2        = s2;
        t.dst_reg          = d;
        t.reg_write_enable = we;
        t.is_l             = l;
        t.is_m             = m;
        t.func3            = f3;
        return t;
    endfunction

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // One cycle: queue the expectation, compare at negedge, step past the next posedge.
    task automatic step(string tag, logic [1:0] eb, logic [1:0] mb,
                        logic ld, logic st, logic fl, logic bz);
        exp_t e;
        e.tag = tag; e.eb = eb; e.mb = mb; e.ld = ld; e.st = st; e.fl = fl; e.bz = bz;
        e.sc  = exp_sc;
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        chk({e.tag, ".exe_bypass"}, {30'd0, hz.exe_bypass}, {30'd0, e.eb});
        chk({e.tag, ".mem_bypass"}, {30'd0, hz.mem_bypass}, {30'd0, e.mb});
        chk({e.tag, ".ld_use"},     {31'd0, hz.load_to_use_hazard}, {31'd0, e.ld});
        chk({e.tag, ".stall"},      {31'd0, hz.stall_fetch}, {31'd0, e.st});
        chk({e.tag, ".flush"},      {31'd0, hz.flush_dec}, {31'd0, e.fl});
        chk({e.tag, ".md_busy"},    {31'd0, hz.md_busy}, {31'd0, e.bz});
        chk({e.tag, ".stall_cyc"},  hz.stall_cycles, e.sc);
        chk({e.tag, ".br_in_md"},   {31'd0, hz.md_busy & hz.branch_taken_in}, 32'd0);
        @(posedge clk);
        #1;
        if (e.st) exp_sc++;
    endtask

    task automatic idle_inputs();
        hz.inst_dec_in     = '0;
        hz.inst_exe_in     = '0;
        hz.inst_mem_in     = '0;
        hz.branch_taken_in = 1'b0;
    endtask

    initial begin
        idle_inputs();
        hz4.inst_dec_in     = '0;
        hz4.inst_exe_in     = '0;
        hz4.inst_mem_in     = '0;
        hz4.branch_taken_in = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset gating: load-use match plus branch while rst is high.
        hz.inst_exe_in     = mk(1, 1, 0, 3, 1, 1, 0, 3'b010);
        hz.inst_dec_in     = mk(1, 4, 3, 8, 1, 0, 0, 3'b000);
        hz.branch_taken_in = 1'b1;
        step("rst_gate", 2'b01, 2'b00, 0, 0, 0, 0);
        rst = 1'b0;
        idle_inputs();
        step("reset_state", 2'b00, 2'b00, 0, 0, 0, 0);

        // Bypass: EXE ADDI x5, MEM writes x7, decode ADD x6,x5,x7.
        hz.inst_exe_in = mk(1, 1, 0, 5, 1, 0, 0, 3'b000);
        hz.inst_mem_in = mk(1, 1, 0, 7, 1, 0, 0, 3'b000);
        hz.inst_dec_in = mk(1, 5, 7, 6, 1, 0, 0, 3'b000);
        step("bypass", 2'b10, 2'b01, 0, 0, 0, 0);
        hz.inst_exe_in = mk(1, 1, 0, 0, 1, 0, 0, 3'b000);
        hz.inst_mem_in = mk(1, 1, 0, 0, 1, 0, 0, 3'b000);
        hz.inst_dec_in = mk(1, 0, 0, 6, 1, 0, 0, 3'b000);
        step("bypass_x0", 2'b00, 2'b00, 0, 0, 0, 0);
        hz.inst_exe_in = mk(1, 1, 0, 5, 1, 0, 0, 3'b000);
        hz.inst_mem_in = mk(1, 1, 0, 5, 1, 0, 0, 3'b000);
        hz.inst_dec_in = mk(1, 5, 5, 6, 1, 0, 0, 3'b000);
        step("bypass_both", 2'b11, 2'b11, 0, 0, 0, 0);
        hz.inst_exe_in = mk(0, 1, 0, 5, 1, 0, 0, 3'b000);
        hz.inst_mem_in = mk(1, 1, 0, 5, 0, 0, 0, 3'b000);
        step("bypass_inval_nowe", 2'b00, 2'b00, 0, 0, 0, 0);

        // Load-use: EXE LW x3, decode reads x3 on src2; EXE kept as-is to exercise the guard state.
        idle_inputs();
        hz.inst_exe_in = mk(1, 1, 0, 3, 1, 1, 0, 3'b010);
        hz.inst_dec_in = mk(1, 4, 3, 8, 1, 0, 0, 3'b000);
        step("lu_detect", 2'b01, 2'b00, 1, 1, 0, 0);
        step("lu_guard", 2'b01, 2'b00, 0, 0, 0, 0);
        idle_inputs();
        step("lu_after", 2'b00, 2'b00, 0, 0, 0, 0);

        // MUL: issue cycle then 2 stall cycles.
        hz.inst_dec_in = mk(1, 10, 11, 12, 1, 0, 1, 3'b000);
        step("mul_issue", 2'b00, 2'b00, 0, 0, 0, 0);
        hz.inst_dec_in = mk(1, 13, 14, 15, 1, 0, 0, 3'b000);
        for (int i = 0; i < 2; i++) step("mul_wait", 2'b00, 2'b00, 1, 1, 0, 1);
        step("mul_done", 2'b00, 2'b00, 0, 0, 0, 0);

        // DIV: issue cycle then 7 stall cycles.
        hz.inst_dec_in = mk(1, 10, 11, 12, 1, 0, 1, 3'b100);
        step("div_issue", 2'b00, 2'b00, 0, 0, 0, 0);
        hz.inst_dec_in = mk(1, 13, 14, 15, 1, 0, 0, 3'b000);
        for (int i = 0; i < 7; i++) step("div_wait", 2'b00, 2'b00, 1, 1, 0, 1);
        step("div_done", 2'b00, 2'b00, 0, 0, 0, 0);

        // Branch flush beats a load-use match; a fresh match next cycle proves the FSM stayed in RUN.
        hz.inst_exe_in     = mk(1, 1, 0, 3, 1, 1, 0, 3'b010);
        hz.inst_dec_in     = mk(1, 3, 9, 8, 1, 0, 0, 3'b000);
        hz.branch_taken_in = 1'b1;
        step("br_flush", 2'b10, 2'b00, 0, 0, 1, 0);
        hz.branch_taken_in = 1'b0;
        step("br_then_lu", 2'b10, 2'b00, 1, 1, 0, 0);
        idle_inputs();
        step("br_lu_guard", 2'b00, 2'b00, 0, 0, 0, 0);

        // Reset in the middle of a DIV.
        hz.inst_dec_in = mk(1, 10, 11, 12, 1, 0, 1, 3'b100);
        step("rdiv_issue", 2'b00, 2'b00, 0, 0, 0, 0);
        hz.inst_dec_in = mk(1, 13, 14, 15, 1, 0, 0, 3'b000);
        for (int i = 0; i < 3; i++) step("rdiv_wait", 2'b00, 2'b00, 1, 1, 0, 1);
        rst = 1'b1;
        step("rdiv_rst", 2'b00, 2'b00, 0, 0, 0, 0);
        exp_sc = 32'd0;
        rst = 1'b0;
        step("rdiv_post", 2'b00, 2'b00, 0, 0, 0, 0);
        hz.inst_dec_in = mk(1, 10, 11, 12, 1, 0, 1, 3'b000);
        step("rmul_issue", 2'b00, 2'b00, 0, 0, 0, 0);
        hz.inst_dec_in = mk(1, 13, 14, 15, 1, 0, 0, 3'b000);
        for (int i = 0; i < 2; i++) step("rmul_wait", 2'b00, 2'b00, 1, 1, 0, 1);
        idle_inputs();
        step("rmul_done", 2'b00, 2'b00, 0, 0, 0, 0);

        // Saturation: 4-bit counter, DIV latency 21 gives 20 stall cycles.
        hz4.inst_dec_in = mk(1, 1, 2, 9, 1, 0, 1, 3'b100);
        @(negedge clk);
        chk("sat_issue.md_busy", {31'd0, hz4.md_busy}, 32'd0);
        chk("sat_issue.stall_cyc", {28'd0, hz4.stall_cycles}, 32'd0);
        @(posedge clk);
        #1;
        hz4.inst_dec_in = mk(1, 1, 2, 9, 1, 0, 0, 3'b000);
        for (int i = 1; i <= 24; i++) begin
            int stalls_so_far;
            stalls_so_far = (i - 1 < 20) ? i - 1 : 20;
            @(negedge clk);
            chk($sformatf("sat_%0d.md_busy", i), {31'd0, hz4.md_busy}, {31'd0, (i <= 20)});
            chk($sformatf("sat_%0d.stall", i), {31'd0, hz4.stall_fetch}, {31'd0, (i <= 20)});
            chk($sformatf("sat_%0d.stall_cyc", i), {28'd0, hz4.stall_cycles},
                32'((stalls_so_far > 15) ? 15 : stalls_so_far));
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
